// File: rtl/wb_merge_queue.sv
`default_nettype none
// ============================================================================
// Module   : wb_merge_queue
// Brief    : Merges up to NUM_SRC writebacks per cycle into an in-order queue
//            draining into a single regfile write port, with forwarding.
// Revision : 1.0
// ============================================================================
module wb_merge_queue #(
    parameter int NUM_SRC = 2,
    parameter int DEPTH   = 4,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_SRC-1:0]        src_valid_i,
    input  logic [NUM_SRC*ADDR_W-1:0] src_addr_i,
    input  logic [NUM_SRC*DATA_W-1:0] src_data_i,
    output logic                      src_ready_o,
    input  logic                      rf_stall_i,
    output logic                      w_enable_o,
    output logic [ADDR_W-1:0]         w_addr_o,
    output logic [DATA_W-1:0]         w_data_o,
    input  logic [ADDR_W-1:0]         fwd_addr_i,
    output logic                      fwd_hit_o,
    output logic [DATA_W-1:0]         fwd_data_o,
    output logic [$clog2(DEPTH+1)-1:0] occ_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic               w_ready;
    logic               w_pop;
    logic [NUM_SRC-1:0] w_acc;
    logic [CNT_W-1:0]   w_off [NUM_SRC];
    logic [PTR_W-1:0]   w_widx [NUM_SRC];
    logic [PTR_W-1:0]   w_qidx [DEPTH];
    logic [CNT_W-1:0]   w_nacc;

    // Ready looks only at the registered count; a same-cycle pop is not credited.
    always_comb begin
        w_ready = (CNT_W'(DEPTH) - r_count) >= CNT_W'(NUM_SRC);
        w_pop   = (r_count != '0) && !rf_stall_i;
    end

    // Accepted sources take consecutive slots; x0 writes are dropped here.
    always_comb begin
        w_nacc = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            w_acc[k]  = w_ready && src_valid_i[k] && (src_addr_i[k*ADDR_W +: ADDR_W] != '0);
            w_off[k]  = w_nacc;
            w_widx[k] = r_wr_ptr + w_nacc[PTR_W-1:0];
            if (w_acc[k]) begin
                w_nacc = w_nacc + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_SRC; k++) begin
            if (w_acc[k]) begin
                r_addr[w_widx[k]] <= src_addr_i[k*ADDR_W +: ADDR_W];
                r_data[w_widx[k]] <= src_data_i[k*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + w_nacc[PTR_W-1:0];
            r_rd_ptr <= r_rd_ptr + {{(PTR_W-1){1'b0}}, w_pop};
            r_count  <= r_count + w_nacc - {{(CNT_W-1){1'b0}}, w_pop};
        end
    end

    always_comb begin
        w_enable_o  = w_pop;
        w_addr_o    = (r_count != '0) ? r_addr[r_rd_ptr] : '0;
        w_data_o    = (r_count != '0) ? r_data[r_rd_ptr] : '0;
        src_ready_o = w_ready;
        occ_o       = r_count;
    end

    // Scan oldest to youngest so later matches override; incoming sources are youngest of all.
    always_comb begin
        fwd_hit_o  = 1'b0;
        fwd_data_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_qidx[i] = r_rd_ptr + PTR_W'(i);
            if ((CNT_W'(i) < r_count) && (r_addr[w_qidx[i]] == fwd_addr_i)) begin
                fwd_hit_o  = 1'b1;
                fwd_data_o = r_data[w_qidx[i]];
            end
        end
        for (int k = 0; k < NUM_SRC; k++) begin
            if (w_acc[k] && (src_addr_i[k*ADDR_W +: ADDR_W] == fwd_addr_i)) begin
                fwd_hit_o  = 1'b1;
                fwd_data_o = src_data_i[k*DATA_W +: DATA_W];
            end
        end
        if (fwd_addr_i == '0) begin
            fwd_hit_o  = 1'b0;
            fwd_data_o = '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_merge_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_merge_queue
// Brief    : Directed self-checking bench with a queue-based reference model.
// Revision : 1.0
// ============================================================================
module tb_wb_merge_queue;

    localparam int NUM_SRC = 2;
    localparam int DEPTH   = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  src_valid_i = '0;
    logic [9:0]  src_addr_i = '0;
    logic [63:0] src_data_i = '0;
    logic        src_ready_o;
    logic        rf_stall_i = 1'b0;
    logic        w_enable_o;
    logic [4:0]  w_addr_o;
    logic [31:0] w_data_o;
    logic [4:0]  fwd_addr_i = '0;
    logic        fwd_hit_o;
    logic [31:0] fwd_data_o;
    logic [2:0]  occ_o;

    int n_checks = 0;
    int n_err    = 0;

    logic [4:0]  mq_a[$];
    logic [31:0] mq_d[$];
    logic [4:0]  wlog[$];
    logic        last_ready;

    always #5 clk = ~clk;

    wb_merge_queue #(.NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .ADDR_W(5), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .src_valid_i(src_valid_i), .src_addr_i(src_addr_i), .src_data_i(src_data_i),
        .src_ready_o(src_ready_o), .rf_stall_i(rf_stall_i),
        .w_enable_o(w_enable_o), .w_addr_o(w_addr_o), .w_data_o(w_data_o),
        .fwd_addr_i(fwd_addr_i), .fwd_hit_o(fwd_hit_o), .fwd_data_o(fwd_data_o),
        .occ_o(occ_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive, compare every output against the model, then advance the model.
    task automatic step(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                        input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                        input logic stall, input logic [4:0] fa);
        logic        e_ready, e_wen, e_hit;
        logic [4:0]  e_wa;
        logic [31:0] e_wd, e_fd;
        logic        sv[2];
        logic [4:0]  sa[2];
        logic [31:0] sd[2];
        @(negedge clk);
        src_valid_i = {v1, v0};
        src_addr_i  = {a1, a0};
        src_data_i  = {d1, d0};
        rf_stall_i  = stall;
        fwd_addr_i  = fa;
        #1;
        sv[0] = v0; sv[1] = v1; sa[0] = a0; sa[1] = a1; sd[0] = d0; sd[1] = d1;
        e_ready = (DEPTH - mq_a.size()) >= NUM_SRC;
        e_wen   = (mq_a.size() != 0) && !stall;
        e_wa    = (mq_a.size() != 0) ? mq_a[0] : 5'd0;
        e_wd    = (mq_a.size() != 0) ? mq_d[0] : 32'd0;
        e_hit   = 1'b0;
        e_fd    = 32'd0;
        if (fa != 5'd0) begin
            for (int k = NUM_SRC - 1; k >= 0 && !e_hit; k--) begin
                if (e_ready && sv[k] && sa[k] != 5'd0 && sa[k] == fa) begin
                    e_hit = 1'b1;
                    e_fd  = sd[k];
                end
            end
            for (int i = mq_a.size() - 1; i >= 0 && !e_hit; i--) begin
                if (mq_a[i] == fa) begin
                    e_hit = 1'b1;
                    e_fd  = mq_d[i];
                end
            end
        end
        chk("ready", {31'd0, src_ready_o}, {31'd0, e_ready});
        chk("wen",   {31'd0, w_enable_o},  {31'd0, e_wen});
        chk("waddr", {27'd0, w_addr_o},    {27'd0, e_wa});
        chk("wdata", w_data_o,             e_wd);
        chk("fhit",  {31'd0, fwd_hit_o},   {31'd0, e_hit});
        chk("fdata", fwd_data_o,           e_fd);
        chk("occ",   {29'd0, occ_o},       32'(mq_a.size()));
        last_ready = e_ready;
        @(posedge clk);
        if (e_wen) begin
            wlog.push_back(mq_a[0]);
            void'(mq_a.pop_front());
            void'(mq_d.pop_front());
        end
        if (e_ready) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                if (sv[k] && sa[k] != 5'd0) begin
                    mq_a.push_back(sa[k]);
                    mq_d.push_back(sd[k]);
                end
            end
        end
        #1;
    endtask

    task automatic idle(input logic stall, input logic [4:0] fa);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, stall, fa);
    endtask

    task automatic drain_all();
        for (int i = 0; i < 12; i++) idle(1'b0, 5'd0);
    endtask

    initial begin
        #2;
        chk("rst_ready", {31'd0, src_ready_o}, 32'd1);
        chk("rst_wen",   {31'd0, w_enable_o},  32'd0);
        chk("rst_occ",   {29'd0, occ_o},       32'd0);
        chk("rst_waddr", {27'd0, w_addr_o},    32'd0);
        chk("rst_fhit",  {31'd0, fwd_hit_o},   32'd0);
        #10 rst_n = 1'b1;

        // 1: same-register pair, youngest forwarded, in-order writes
        step(1'b1, 5'd5, 32'h11, 1'b1, 5'd5, 32'h22, 1'b0, 5'd5);
        src_valid_i = '0; rf_stall_i = 1'b0; fwd_addr_i = 5'd5; #1;
        chk("t1_occ",   {29'd0, occ_o},     32'd2);
        chk("t1_fdata", fwd_data_o,         32'h22);
        chk("t1_waddr", {27'd0, w_addr_o},  32'd5);
        chk("t1_wdata", w_data_o,           32'h11);
        idle(1'b0, 5'd5);
        idle(1'b0, 5'd5);
        idle(1'b0, 5'd5);

        // 2: x0 write consumes nothing
        step(1'b1, 5'd0, 32'hFF, 1'b1, 5'd3, 32'h33, 1'b1, 5'd0);
        chk("t2_occ",  {29'd0, occ_o},     32'd1);
        chk("t2_fhit", {31'd0, fwd_hit_o}, 32'd0);
        idle(1'b0, 5'd3);
        idle(1'b0, 5'd0);

        // 3: fill under stall, hold a third pair, then release
        step(1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hA2, 1'b1, 5'd2);
        step(1'b1, 5'd3, 32'hA3, 1'b1, 5'd4, 32'hA4, 1'b1, 5'd1);
        chk("t3_occ",   {29'd0, occ_o},       32'd4);
        chk("t3_ready", {31'd0, src_ready_o}, 32'd0);
        step(1'b1, 5'd5, 32'hA5, 1'b1, 5'd6, 32'hA6, 1'b1, 5'd5);
        step(1'b1, 5'd5, 32'hA5, 1'b1, 5'd6, 32'hA6, 1'b1, 5'd4);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 5'd5, 32'hA5, 1'b1, 5'd6, 32'hA6, 1'b0, 5'd6);
            if (last_ready) break;
        end
        drain_all();

        // 4: occupancy holds when one entry enters while one leaves
        step(1'b1, 5'd7, 32'hB7, 1'b1, 5'd8, 32'hB8, 1'b1, 5'd7);
        step(1'b1, 5'd9, 32'hB9, 1'b0, 5'd0, 32'h0, 1'b0, 5'd8);
        chk("t4_occ",   {29'd0, occ_o},    32'd2);
        chk("t4_waddr", {27'd0, w_addr_o}, 32'd8);
        drain_all();

        // 5: stream r1..r20 through wrapping pointers
        wlog.delete();
        begin
            int p = 0;
            for (int c = 0; c < 200 && p < 10; c++) begin
                step(1'b1, 5'(2*p+1), 32'(16'hC00 + 2*p+1), 1'b1, 5'(2*p+2), 32'(16'hC00 + 2*p+2),
                     1'b0, 5'(2*p+1));
                if (last_ready) p++;
            end
            chk("t5_sent", 32'(p), 32'd10);
        end
        drain_all();
        chk("t5_count", 32'(wlog.size()), 32'd20);
        for (int i = 0; i < 20 && i < wlog.size(); i++)
            chk("t5_order", {27'd0, wlog[i]}, 32'(i + 1));

        // 6: asynchronous reset with entries pending
        step(1'b1, 5'd10, 32'hD0, 1'b1, 5'd11, 32'hD1, 1'b1, 5'd0);
        step(1'b1, 5'd12, 32'hD2, 1'b0, 5'd0,  32'h0,  1'b1, 5'd0);
        chk("t6_occ3", {29'd0, occ_o}, 32'd3);
        @(negedge clk);
        src_valid_i = '0; rf_stall_i = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("t6_wen", {31'd0, w_enable_o}, 32'd0);
        chk("t6_occ", {29'd0, occ_o},      32'd0);
        mq_a.delete(); mq_d.delete();
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 4; i++) idle(1'b0, 5'd10);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
